// File: rtl/lc3_mem_pkg.sv
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared definitions for the LC-3 memory subsystem: port-ID
//               encoding and default data/address widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_mem_pkg;

  // Identity of the arbiter port that owns a memory access.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int ADDRESS_SIZE_DEF = 16;

endpackage : lc3_mem_pkg

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port single-RAM arbiter. Port A (CPU) and port B
//               (loader/debug) share one synchronous RAM. Round-robin between
//               the ports, with a bounded sticky-priority mode for B bursts.
//               Read data returns one cycle after grant, tagged by rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int LOCK_MAX     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  // Port A (CPU)
  input  logic                    a_req,
  input  logic                    a_write,
  input  logic [ADDRESS_SIZE-1:0] a_address,
  input  logic [WORD_SIZE-1:0]    a_in_data,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  // Port B (loader/debug)
  input  logic                    b_req,
  input  logic                    b_write,
  input  logic [ADDRESS_SIZE-1:0] b_address,
  input  logic [WORD_SIZE-1:0]    b_in_data,
  input  logic                    b_lock,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  // Shared read data
  output logic [WORD_SIZE-1:0]    out_data,
  // RAM side
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]    mem_in_data,
  input  logic [WORD_SIZE-1:0]    mem_out_data
);

  localparam int          CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] c_LOCK_MAX = CNT_W'(LOCK_MAX);

  port_id_e         r_last;       // port granted most recently
  logic [CNT_W-1:0] r_lock_cnt;   // consecutive B grants while A waits
  logic             r_a_rvalid;
  logic             r_b_rvalid;

  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_lock_full;
  logic             w_gnt_write;

  assign w_lock_full = (r_lock_cnt == c_LOCK_MAX);

  // Grant decision: single requester wins outright; contention is settled by
  // round-robin, except that a locked B keeps the bus until the lock budget
  // runs out, at which point A gets exactly one access.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (a_req && !b_req) begin
        w_gnt_a = 1'b1;
      end else if (b_req && !a_req) begin
        w_gnt_b = 1'b1;
      end else if (a_req && b_req) begin
        if (b_lock && (r_last == PORT_B)) begin
          if (w_lock_full) begin
            w_gnt_a = 1'b1;
          end else begin
            w_gnt_b = 1'b1;
          end
        end else if (r_last == PORT_B) begin
          w_gnt_a = 1'b1;
        end else begin
          w_gnt_b = 1'b1;
        end
      end
    end
  end

  assign a_gnt = w_gnt_a;
  assign b_gnt = w_gnt_b;

  // RAM strobes and operands follow the granted port in the grant cycle.
  always_comb begin
    w_gnt_write = 1'b0;
    mem_address = a_address;
    mem_in_data = a_in_data;
    if (w_gnt_b) begin
      w_gnt_write = b_write;
      mem_address = b_address;
      mem_in_data = b_in_data;
    end else if (w_gnt_a) begin
      w_gnt_write = a_write;
    end
  end

  assign mem_write = (w_gnt_a || w_gnt_b) &&  w_gnt_write;
  assign mem_read  = (w_gnt_a || w_gnt_b) && !w_gnt_write;

  // Track last owner and the lock budget; the budget only accrues while A is
  // actually being held off, and any A grant or dropped lock refills it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last     <= PORT_B;
      r_lock_cnt <= '0;
    end else begin
      if (w_gnt_a) begin
        r_last <= PORT_A;
      end else if (w_gnt_b) begin
        r_last <= PORT_B;
      end

      if (w_gnt_a || !b_lock) begin
        r_lock_cnt <= '0;
      end else if (w_gnt_b && a_req && !w_lock_full) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end
  end

  // Read-return pipeline: matches the RAM's one-cycle read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_gnt_a && !a_write;
      r_b_rvalid <= w_gnt_b && !b_write;
    end
  end

  // Masking with reset kills a return whose read was granted just before
  // reset was raised, so it never appears while or after reset is applied.
  assign a_rvalid = r_a_rvalid && !reset;
  assign b_rvalid = r_b_rvalid && !reset;
  assign out_data = mem_out_data;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               synchronous RAM model behind the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int WS = 16;
  localparam int AS = 16;
  localparam int LM = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_write, a_gnt, a_rvalid;
  logic [AS-1:0] a_address;
  logic [WS-1:0] a_in_data;
  logic          b_req, b_write, b_lock, b_gnt, b_rvalid;
  logic [AS-1:0] b_address;
  logic [WS-1:0] b_in_data;
  logic [WS-1:0] out_data;
  logic          mem_read, mem_write;
  logic [AS-1:0] mem_address;
  logic [WS-1:0] mem_in_data;
  logic [WS-1:0] mem_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .LOCK_MAX(LM)) dut (
    .clock        (clock),
    .reset        (reset),
    .a_req        (a_req),
    .a_write      (a_write),
    .a_address    (a_address),
    .a_in_data    (a_in_data),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .b_req        (b_req),
    .b_write      (b_write),
    .b_address    (b_address),
    .b_in_data    (b_in_data),
    .b_lock       (b_lock),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .out_data     (out_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_out_data (mem_out_data)
  );

  // Synchronous RAM: write-through array, registered read, 1-cycle latency.
  logic [WS-1:0] ram [0:511];
  logic          ram_init = 1'b0;
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
      ram[4]   <= 16'h0008;
      ram_init <= 1'b1;
    end else begin
      if (mem_write) ram[mem_address[8:0]] <= mem_in_data;
      if (mem_read)  mem_out_data <= ram[mem_address[8:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                       input logic bl);
    a_req = ar; a_write = aw; a_address = aa; a_in_data = ad;
    b_req = br; b_write = bw; b_address = ba; b_in_data = bd;
    b_lock = bl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Structural invariants every cycle, away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      chk("inv_rd_wr",  {31'd0, mem_read && mem_write}, 32'd0);
      chk("inv_gnt",    {31'd0, a_gnt && b_gnt},        32'd0);
      chk("inv_rvalid", {31'd0, a_rvalid && b_rvalid},  32'd0);
    end
  end

  initial begin
    logic  exp_b;
    int    bcnt;

    // Reset with both ports requesting: nothing may be granted.
    reset = 1'b1;
    drive(1, 0, 16'h0004, 0, 1, 0, 16'h0007, 0, 0);
    #1;
    chk("rst_a_gnt", {31'd0, a_gnt},     0);
    chk("rst_b_gnt", {31'd0, b_gnt},     0);
    chk("rst_mrd",   {31'd0, mem_read},  0);
    chk("rst_mwr",   {31'd0, mem_write}, 0);
    tick();
    chk("rst_a_rv",  {31'd0, a_rvalid},  0);
    chk("rst_b_rv",  {31'd0, b_rvalid},  0);
    tick();
    reset = 1'b0;

    // Only A reads 0x0004 -> same-cycle grant, data 0x0008 next cycle.
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0);
    #1;
    chk("a_only_gnt",  {31'd0, a_gnt},    1);
    chk("a_only_bgnt", {31'd0, b_gnt},    0);
    chk("a_only_mrd",  {31'd0, mem_read}, 1);
    chk("a_only_addr", {16'd0, mem_address}, 32'h0004);
    tick();
    chk("a_only_rv",   {31'd0, a_rvalid}, 1);
    chk("a_only_brv",  {31'd0, b_rvalid}, 0);
    chk("a_only_data", {16'd0, out_data}, 32'h0008);

    // B writes 0x1234 to 0x0007, then reads it back next cycle.
    drive(0, 0, 0, 0, 1, 1, 16'h0007, 16'h1234, 0);
    #1;
    chk("b_wr_gnt",  {31'd0, b_gnt},     1);
    chk("b_wr_mwr",  {31'd0, mem_write}, 1);
    chk("b_wr_mrd",  {31'd0, mem_read},  0);
    chk("b_wr_data", {16'd0, mem_in_data}, 32'h1234);
    tick();
    chk("b_wr_norv", {31'd0, b_rvalid},  0);
    drive(0, 0, 0, 0, 1, 0, 16'h0007, 0, 0);
    #1;
    chk("b_rd_gnt",  {31'd0, b_gnt},     1);
    tick();
    chk("b_rd_rv",   {31'd0, b_rvalid},  1);
    chk("b_rd_arv",  {31'd0, a_rvalid},  0);
    chk("b_rd_data", {16'd0, out_data},  32'h1234);

    // Both reading, no lock: strict alternation A, B, A, B.
    drive(1, 0, 16'h0004, 0, 1, 0, 16'h0007, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_gnt", {31'd0, b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("rr_a_rv",  {31'd0, a_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_rv",  {31'd0, b_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_data",  {16'd0, out_data}, (i % 2 == 0) ? 32'h0008 : 32'h1234);
    end

    // Locked B burst of 20 writes against a waiting A: 16 B, 1 A, then B.
    bcnt = 0;
    for (int c = 0; c < 22; c++) begin
      drive(1, 0, 16'h0004, 0, (bcnt < 20), 1, 16'h0100 + 16'(bcnt), 16'(bcnt), 1);
      exp_b = (c < 16) || (c >= 17 && c <= 20);
      #1;
      chk("lk_b_gnt", {31'd0, b_gnt}, {31'd0, exp_b});
      chk("lk_a_gnt", {31'd0, a_gnt}, {31'd0, !exp_b});
      if (exp_b) begin
        chk("lk_mwr",  {31'd0, mem_write},   1);
        chk("lk_addr", {16'd0, mem_address}, 32'h0100 + bcnt);
        bcnt++;
      end
      tick();
      chk("lk_a_rv", {31'd0, a_rvalid}, (c == 16 || c == 21) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("lk_ram_last",  {16'd0, ram[9'h113]}, 32'h0013);
    chk("lk_ram_first", {16'd0, ram[9'h100]}, 32'h0000);
    chk("lk_ram_16",    {16'd0, ram[9'h110]}, 32'h0010);

    // A read granted, reset raised the following cycle: no stale rvalid.
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rr_pre_gnt", {31'd0, a_gnt}, 1);
    tick();
    reset = 1'b1;
    drive(1, 0, 16'h0004, 0, 1, 0, 16'h0007, 0, 0);
    #1;
    chk("rst_kill_rv",  {31'd0, a_rvalid}, 0);
    chk("rst_kill_gnt", {31'd0, a_gnt || b_gnt}, 0);
    chk("rst_kill_mrd", {31'd0, mem_read}, 0);
    tick();
    chk("rst_kill_rv2", {31'd0, a_rvalid}, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_a", {31'd0, a_gnt}, 1);
    chk("post_rst_b", {31'd0, b_gnt}, 0);
    tick();
    chk("post_rst_rv",   {31'd0, a_rvalid}, 1);
    chk("post_rst_data", {16'd0, out_data}, 32'h0008);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire
